mul_issue_ctrl: RTL
===================

# mul_issue_ctrl

Sequencing and result-formatting stage for the RV32M multiply path. It accepts one multiply request at a time from the EX stage over a valid/ready handshake and drives the iterative signed Booth multiplier (32×32→64, held in reset while its reset is high, `done` on completion). It captures the 64-bit product, applies sign correction for MULHSU/MULHU, and returns a 32-bit result to writeback over a second valid/ready handshake. A one-entry operand/product cache lets a MULH[S][U]+MUL pair on identical operands complete without a second multiplier run.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `in_a`  in  32  rs1 value.
- `in_b`  in  32  rs2 value.
- `flush`  in  1  kill any in-flight request.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  writeback accepts when `out_valid & out_ready`.
- `out_result`  out  32  formatted result.
- `mul_a`, `mul_b`  out  32  multiplier operands (registered).
- `mul_rst`  out  1  multiplier reset/start; high holds it cleared, falling edge starts it.
- `mul_p`  in  64  signed product from the multiplier.
- `mul_done`  in  1  multiplier finished, `mul_p` valid.

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE: `in_ready`=1, `mul_rst`=1. On accept, latch op/a/b. Cache hit (cache_valid, a==cache_a, b==cache_b) → RESP; otherwise → LOAD.
- LOAD (exactly 1 cycle): `mul_a`/`mul_b` hold latched operands, `mul_rst`=1 → RUN.
- RUN: `mul_rst`=0; wait for `mul_done`. On `mul_done`, capture `mul_p` into prod, write cache (cache_a, cache_b, cache_p, cache_valid=1) → RESP.
- RESP: `out_valid`=1; on `out_ready` → IDLE. No new request accepted in RESP.
- Result format, where S = signed 64-bit product, lo = S[31:0], hi = S[63:32], all sums mod 2^32:
  - MUL: lo.
  - MULH: hi.
  - MULHSU: hi + (b[31] ? a : 0).
  - MULHU: hi + (a[31] ? b : 0) + (b[31] ? a : 0).
- `out_result` is a function of registered prod/op/a/b only. It is stable through RESP.
- `flush`: from any state → IDLE next cycle. It drops `out_valid` and reasserts `mul_rst`. No accept in the flush cycle, even if `in_valid` and `in_ready` are both high. The cache is updated only on `mul_done` in RUN, so an aborted run leaves it unchanged.
- `rst`: immediate → IDLE; cache_valid=0; all operand/product registers 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `mul_a`=0, `mul_b`=0, `mul_rst`=1.
- Miss latency: accept at cycle 0, LOAD at cycle 1, RUN from cycle 2. `out_valid` rises on the cycle after `mul_done` is sampled high.
- Hit latency: accept at cycle 0, `out_valid`=1 at cycle 1. `mul_rst` stays high throughout.
- `mul_done` is ignored outside RUN.
- `mul_a`/`mul_b` change only on the LOAD entry edge.
- Back-to-back: after the RESP handshake, IDLE lasts at least 1 cycle before the next accept.
- `out_valid`, once high, stays high with constant `out_result` until handshake, `flush`, or `rst`.

## Test plan
- Miss, MUL: a=7, b=0xFFFFFFFD. Expect `out_result`=0xFFFFFFEB; `out_valid` exactly one cycle after `mul_done`.
- Correction for all four ops on a=0xFFFFFFFF, b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - MULH → 0x00000000.
  - MUL → 0x00000001.
  - Separately, MULH on a=b=0x80000000 → 0x40000000.
- Cache hit: MULH on a=0x12345678, b=0x9ABCDEF0, then MUL on the same operands. Expect the second `out_valid` 1 cycle after accept, `mul_rst` high throughout, result 0x242D2080. A third request with b changed must miss and rerun.
- Backpressure: hold `out_ready`=0 for 5 cycles in RESP. Expect `out_valid` and `out_result` constant and `in_ready`=0. Handshake on cycle 6 → IDLE.
- Flush in RUN (before `mul_done`): next cycle IDLE, `out_valid` never rises, `mul_rst`=1. A following request with the same operands must miss, confirming no cache write.
- Async reset asserted mid-RUN: outputs take reset values without waiting for a clock edge. After release, a MUL 3×5 → 15 via the miss path.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Sequencing and result-formatting stage for the RV32M multiply path.
//   Accepts one multiply request at a time, runs the iterative signed
//   multiplier, applies unsigned-operand correction for MULHSU/MULHU and
//   hands a 32-bit result to writeback. A one-entry operand/product cache
//   lets a MULH[S][U]+MUL pair on identical operands skip a second run.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   in_valid/in_ready      request handshake
//   in_op                  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b             rs1 / rs2 values
//   flush                  kill any in-flight request
//   out_valid/out_ready    result handshake
//   out_result             formatted result
//   mul_a, mul_b           registered multiplier operands
//   mul_rst                multiplier hold/start (falling edge starts a run)
//   mul_p, mul_done        signed product and completion from the multiplier
module mul_issue_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [XLEN-1:0]   mul_a,
   output logic [XLEN-1:0]   mul_b,
   output logic              mul_rst,
   input  logic [2*XLEN-1:0] mul_p,
   input  logic              mul_done
);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_load = 2'd1;
   localparam logic [1:0] st_run  = 2'd2;
   localparam logic [1:0] st_resp = 2'd3;

   localparam logic [1:0] op_mul    = 2'b00;
   localparam logic [1:0] op_mulh   = 2'b01;
   localparam logic [1:0] op_mulhsu = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q;
   logic [XLEN-1:0]   mul_a_q, mul_b_q;
   logic [2*XLEN-1:0] prod_q;
   logic              cache_valid_q;
   logic [XLEN-1:0]   cache_a_q, cache_b_q;
   logic [2*XLEN-1:0] cache_p_q;

   logic accept;
   logic hit;
   logic run_done;

   // in_ready is not gated by flush; flush instead suppresses the accept.
   assign in_ready = (state_q == st_idle);
   assign accept   = in_ready & in_valid & ~flush;
   assign hit      = cache_valid_q & (in_a == cache_a_q) & (in_b == cache_b_q);
   assign run_done = (state_q == st_run) & mul_done & ~flush;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = st_idle;
      end else begin
         case (state_q)
            st_idle: if (in_valid) state_d = hit ? st_resp : st_load;
            st_load: state_d = st_run;
            st_run:  if (mul_done) state_d = st_resp;
            st_resp: if (out_ready) state_d = st_idle;
            default: state_d = st_idle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= st_idle;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         prod_q        <= '0;
         cache_valid_q <= 1'b0;
         cache_a_q     <= '0;
         cache_b_q     <= '0;
         cache_p_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            if (hit) begin
               prod_q <= cache_p_q;
            end else begin
               // Multiplier operands only move on the edge that enters LOAD.
               mul_a_q <= in_a;
               mul_b_q <= in_b;
            end
         end
         // Cache is written only by a completed run, so a flushed run
         // leaves the previous entry intact.
         if (run_done) begin
            prod_q        <= mul_p;
            cache_valid_q <= 1'b1;
            cache_a_q     <= mul_a_q;
            cache_b_q     <= mul_b_q;
            cache_p_q     <= mul_p;
         end
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_rst   = (state_q != st_run);
   assign out_valid = (state_q == st_resp);

   // The multiplier is signed x signed. Treating an operand as unsigned
   // adds 2^32 * (other operand) when its top bit is set, which only
   // affects the upper word.
   logic [XLEN-1:0] prod_lo, prod_hi;
   logic [XLEN-1:0] corr_a, corr_b;

   assign prod_lo = prod_q[XLEN-1:0];
   assign prod_hi = prod_q[2*XLEN-1:XLEN];
   assign corr_a  = b_q[XLEN-1] ? a_q : '0;
   assign corr_b  = a_q[XLEN-1] ? b_q : '0;

   always_comb begin
      out_result = '0;
      case (op_q)
         op_mul:    out_result = prod_lo;
         op_mulh:   out_result = prod_hi;
         op_mulhsu: out_result = prod_hi + corr_a;
         default:   out_result = prod_hi + corr_a + corr_b;
      endcase
   end

endmodule
